// File: rtl/mips_pkg.sv
// Shared constants and types for the 5-stage MIPS core front end.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear (flush) beats enable; bubble injects a NOP but keeps pcplus4.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clear,
  input  logic            bubble,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pcplus4_in,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pcplus4,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      instr   <= NOP_INSTR;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (en) begin
      if (bubble) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else begin
        instr   <= instr_in;
        pcplus4 <= pcplus4_in;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem requests, and feeds the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0]     NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            pcsrcD,
  input  logic [PC_W-1:0] pcbranchD,
  input  logic            jumpD,
  input  logic            jrD,
  input  logic [PC_W-1:0] srcaD,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pcF,
  output logic [31:0]     instrD,
  output logic [PC_W-1:0] pcplus4D,
  output logic            validD,
  output logic            imem_busy
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pend_pc, pend_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pcplus4F;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            ifid_clear;
  logic            ifid_bubble;

  assign pcplus4F  = pcF + 32'd4;
  assign redirect  = ~stallD & (jrD | jumpD | pcsrcD);
  assign imem_req  = ~reset;
  assign imem_addr = pcF;
  assign imem_busy = imem_req & ~imem_ready;

  always_comb begin
    if (jrD)
      target = srcaD;
    else if (jumpD)
      target = {pcplus4D[31:28], instrD[25:0], 2'b00};
    else
      target = pcbranchD;
  end

  always_comb begin
    state_next  = state;
    pc_next     = pcF;
    pend_next   = pend_pc;
    ifid_clear  = 1'b0;
    ifid_bubble = 1'b0;
    unique case (state)
      RUN: begin
        ifid_clear  = redirect;
        ifid_bubble = ~imem_ready;
        if (imem_ready) begin
          if (redirect)
            pc_next = target;
          else if (!stallF)
            pc_next = pcplus4F;
        end else if (redirect) begin
          pend_next  = target;
          state_next = SQUASH;
        end
      end
      SQUASH: begin
        // The in-flight word belongs to the wrong path; a redirect arriving
        // in the completion cycle must still win over the older pending one.
        ifid_bubble = 1'b1;
        if (redirect)
          pend_next = target;
        if (imem_ready) begin
          pc_next    = redirect ? target : pend_pc;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pcF     <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_next;
      pcF     <= pc_next;
      pend_pc <= pend_next;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk       (clk),
    .reset     (reset),
    .en        (~stallD),
    .clear     (ifid_clear),
    .bubble    (ifid_bubble),
    .instr_in  (imem_rdata),
    .pcplus4_in(pcplus4F),
    .instr     (instrD),
    .pcplus4   (pcplus4D),
    .valid     (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the memory echoes the address unless a word is forced.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stallF, stallD, pcsrcD, jumpD, jrD;
  logic [31:0] pcbranchD, srcaD;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req, imem_ready, imem_busy;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;
  logic        use_word;
  logic [31:0] word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = use_word ? word : imem_addr;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stallF    (stallF),
    .stallD    (stallD),
    .pcsrcD    (pcsrcD),
    .pcbranchD (pcbranchD),
    .jumpD     (jumpD),
    .jrD       (jrD),
    .srcaD     (srcaD),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .pcF       (pcF),
    .instrD    (instrD),
    .pcplus4D  (pcplus4D),
    .validD    (validD),
    .imem_busy (imem_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (pcF !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pcF, 32'h0); end
    checks++; if (validD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", validD); end
    checks++; if (instrD !== 32'h0 || pcplus4D !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h exp 0/0", instrD, pcplus4D); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL req_after_reset: got %b/%h exp 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    step();
    checks++; if (pcF !== 32'h4) begin errors++; $display("FAIL seq_pc1: got %h exp 4", pcF); end
    checks++; if (instrD !== 32'h0 || validD !== 1'b1 || pcplus4D !== 32'h4) begin errors++; $display("FAIL seq_d1: got %h/%b/%h exp 0/1/4", instrD, validD, pcplus4D); end
    step();
    checks++; if (pcF !== 32'h8) begin errors++; $display("FAIL seq_pc2: got %h exp 8", pcF); end
    checks++; if (instrD !== 32'h4 || validD !== 1'b1 || pcplus4D !== 32'h8) begin errors++; $display("FAIL seq_d2: got %h/%b/%h exp 4/1/8", instrD, validD, pcplus4D); end
    checks++; if (imem_busy !== 1'b0) begin errors++; $display("FAIL seq_busy: got %b exp 0", imem_busy); end
  endtask

  task automatic test_stall();
    stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pcF !== 32'h8 || instrD !== 32'h4 || pcplus4D !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%h exp 8/4/8", i, pcF, instrD, pcplus4D); end
    end
    stallF = 1'b0; stallD = 1'b0;
    step();
    checks++; if (pcF !== 32'hC || instrD !== 32'h8 || pcplus4D !== 32'hC || validD !== 1'b1) begin errors++; $display("FAIL stall_release: got %h/%h/%h/%b exp C/8/C/1", pcF, instrD, pcplus4D, validD); end
  endtask

  task automatic test_branch();
    pcsrcD = 1'b1; pcbranchD = 32'h40; stallF = 1'b1;
    step();
    checks++; if (pcF !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h exp 40", pcF); end
    checks++; if (instrD !== 32'h0 || validD !== 1'b0 || pcplus4D !== 32'h0) begin errors++; $display("FAIL branch_flush: got %h/%b/%h exp 0/0/0", instrD, validD, pcplus4D); end
    pcsrcD = 1'b0; stallF = 1'b0;
    step();
    checks++; if (pcF !== 32'h44 || instrD !== 32'h40 || validD !== 1'b1 || pcplus4D !== 32'h44) begin errors++; $display("FAIL branch_target_word: got %h/%h/%b/%h exp 44/40/1/44", pcF, instrD, validD, pcplus4D); end
  endtask

  task automatic test_jr_jump();
    jrD = 1'b1; jumpD = 1'b1; srcaD = 32'h100;
    step();
    checks++; if (pcF !== 32'h100 || validD !== 1'b0) begin errors++; $display("FAIL jr_priority: got %h/%b exp 100/0", pcF, validD); end
    jrD = 1'b0; jumpD = 1'b0; use_word = 1'b1; word = 32'h0800_0010;
    step();
    checks++; if (pcF !== 32'h104 || instrD !== 32'h0800_0010 || pcplus4D !== 32'h104) begin errors++; $display("FAIL j_fetch: got %h/%h/%h exp 104/08000010/104", pcF, instrD, pcplus4D); end
    use_word = 1'b0; jumpD = 1'b1;
    step();
    checks++; if (pcF !== 32'h40 || validD !== 1'b0) begin errors++; $display("FAIL j_target: got %h/%b exp 40/0", pcF, validD); end
    jumpD = 1'b0;
  endtask

  task automatic test_mem_wait();
    pcsrcD = 1'b1; pcbranchD = 32'h20;
    step();
    pcsrcD = 1'b0; imem_ready = 1'b0;
    #1;
    checks++; if (imem_busy !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL wait_busy: got %b/%h exp 1/20", imem_busy, imem_addr); end
    step();
    checks++; if (pcF !== 32'h20 || validD !== 1'b0) begin errors++; $display("FAIL wait_c1: got %h/%b exp 20/0", pcF, validD); end
    pcsrcD = 1'b1; pcbranchD = 32'h80;
    step();
    checks++; if (imem_addr !== 32'h20 || validD !== 1'b0) begin errors++; $display("FAIL wait_c2: got %h/%b exp 20/0", imem_addr, validD); end
    pcsrcD = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h20 || imem_busy !== 1'b1 || validD !== 1'b0) begin errors++; $display("FAIL wait_c3: got %h/%b/%b exp 20/1/0", imem_addr, imem_busy, validD); end
    imem_ready = 1'b1;
    step();
    checks++; if (pcF !== 32'h80 || validD !== 1'b0 || instrD !== 32'h0) begin errors++; $display("FAIL squash_done: got %h/%b/%h exp 80/0/0", pcF, validD, instrD); end
    step();
    checks++; if (pcF !== 32'h84 || instrD !== 32'h80 || validD !== 1'b1) begin errors++; $display("FAIL squash_resume: got %h/%h/%b exp 84/80/1", pcF, instrD, validD); end
  endtask

  task automatic test_bubble();
    imem_ready = 1'b0;
    step();
    checks++; if (pcF !== 32'h84 || instrD !== 32'h0 || validD !== 1'b0 || pcplus4D !== 32'h84) begin errors++; $display("FAIL bubble: got %h/%h/%b/%h exp 84/0/0/84", pcF, instrD, validD, pcplus4D); end
    imem_ready = 1'b1;
    step();
    checks++; if (pcF !== 32'h88 || instrD !== 32'h84 || pcplus4D !== 32'h88) begin errors++; $display("FAIL bubble_resume: got %h/%h/%h exp 88/84/88", pcF, instrD, pcplus4D); end
  endtask

  task automatic test_redirect_stalled();
    stallF = 1'b1; stallD = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h200;
    step();
    checks++; if (pcF !== 32'h88 || instrD !== 32'h84 || validD !== 1'b1) begin errors++; $display("FAIL redir_stalled: got %h/%h/%b exp 88/84/1", pcF, instrD, validD); end
    stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
    step();
    checks++; if (pcF !== 32'h8C || instrD !== 32'h88) begin errors++; $display("FAIL redir_stalled_after: got %h/%h exp 8C/88", pcF, instrD); end
  endtask

  task automatic test_reset_squash();
    imem_ready = 1'b0; pcsrcD = 1'b1; pcbranchD = 32'h300;
    step();
    pcsrcD = 1'b0; reset = 1'b1;
    step();
    checks++; if (pcF !== 32'h0 || validD !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_squash: got %h/%b/%b exp 0/0/0", pcF, validD, imem_req); end
    reset = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (pcF !== 32'h4 || instrD !== 32'h0 || validD !== 1'b1) begin errors++; $display("FAIL rst_squash_run: got %h/%h/%b exp 4/0/1", pcF, instrD, validD); end
  endtask

  task automatic test_wrap();
    pcsrcD = 1'b1; pcbranchD = 32'hFFFF_FFFC;
    step();
    pcsrcD = 1'b0;
    checks++; if (pcF !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h exp FFFFFFFC", pcF); end
    step();
    checks++; if (pcF !== 32'h0 || pcplus4D !== 32'h0 || instrD !== 32'hFFFF_FFFC || validD !== 1'b1) begin errors++; $display("FAIL wrap: got %h/%h/%h/%b exp 0/0/FFFFFFFC/1", pcF, pcplus4D, instrD, validD); end
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0; jrD = 1'b0;
    pcbranchD = '0; srcaD = '0; imem_ready = 1'b1; use_word = 1'b0; word = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jr_jump();
    test_mem_wait();
    test_bubble();
    test_redirect_stalled();
    test_reset_squash();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and drives the instruction-memory request.
- Consumes stallF/stallD from the hazard unit and branch/jump/jr redirects resolved in Decode.
- Produces instrD/pcplus4D/validD for Decode. Tolerates a multi-cycle instruction memory via a ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into ID on bubble/flush (sll $0,$0,0).

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stallF  in  1  hazard unit: hold PC
- stallD  in  1  hazard unit: hold IF/ID
- pcsrcD  in  1  branch (beq/bne) taken, resolved in D
- pcbranchD  in  32  branch target from D
- jumpD  in  1  j/jal decoded in D
- jrD  in  1  jr decoded in D
- srcaD  in  32  forwarded rs value in D (jr target)
- imem_addr  out  32  fetch address (= pcF)
- imem_req  out  1  fetch request valid
- imem_rdata  in  32  instruction word, valid when imem_ready
- imem_ready  in  1  memory completes the current request this cycle
- pcF  out  32  current fetch PC
- instrD  out  32  IF/ID instruction
- pcplus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction
- imem_busy  out  1  fetch is waiting on memory (for perf/debug)

Behaviour:
- Reset, applied in the cycle reset=1:
  - pcF=RESET_PC, instrD=NOP_INSTR, pcplus4D=0, validD=0, state=RUN, pend_pc=0.
  - imem_req=0 during reset.
  - Reset mid-operation drops any pending redirect and squash.
- redirect = ~stallD & (jrD | jumpD | pcsrcD). Redirects while stallD=1 are ignored; D re-evaluates next cycle.
- Target priority: jrD -> srcaD; else jumpD -> {pcplus4D[31:28], instrD[25:0], 2'b00}; else pcbranchD.
- Request rule: imem_req=1 and imem_addr=pcF in every non-reset cycle. Address is stable while imem_req=1 & imem_ready=0.
- State RUN, imem_ready=1:
  - PC: redirect -> pcF<=target; else ~stallF -> pcF<=pcF+4; else hold. stallF discards the word, and the same address is refetched next cycle.
  - IF/ID: redirect -> clear (instrD=NOP_INSTR, pcplus4D=0, validD=0); else stallD -> hold; else load imem_rdata, pcF+4, validD=1.
- State RUN, imem_ready=0:
  - pcF held.
  - IF/ID: redirect -> clear; else stallD -> hold; else bubble (NOP_INSTR, validD=0, pcplus4D held).
  - If redirect: pend_pc<=target, state->SQUASH.
- State SQUASH: old request is still outstanding at pcF.
  - IF/ID: stallD -> hold, else bubble.
  - A further redirect in SQUASH overwrites pend_pc.
  - When imem_ready=1: data discarded, pcF<=pend_pc, state->RUN.
- imem_busy = imem_req & ~imem_ready.
- Simultaneous stallF=1 and redirect: redirect wins; pcF updated.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Low two bits of targets are passed through unchecked.
- Latency: one cycle from imem_ready to instrD, with zero-wait memory giving one instruction per cycle.

Decomposition:
- Package mips_pkg holds:
  - NOP_INSTR and RESET_PC defaults.
  - fetch_state_t enum {RUN, SQUASH}.
  - PC width constant (32).
- Sub-module ifid_reg: IF/ID flop with sync reset, enable (~stallD) and clear (flushD / bubble), holding instr, pcplus4, valid.

Test Plan:
- Reset then zero-wait memory returning addr as data, no stalls -> pcF 0,4,8,C on successive cycles; instrD lags one cycle with validD=1, pcplus4D=4,8,C.
- stallF=stallD=1 for 2 cycles at pcF=8 -> pcF stays 8, instrD holds word from 4; after release, instrD=word@8, pcplus4D=C.
- Branch: pcsrcD=1, pcbranchD=0x40 at pcF=C -> next pcF=0x40, instrD=NOP_INSTR, validD=0; following cycle instrD=word@0x40.
- jr with srcaD=0x100 and jumpD=1 simultaneously -> pcF=0x100 (jr priority). Then j with instrD[25:0]=0x10, pcplus4D=0x104 -> pcF=0x40.
- imem_ready low 3 cycles at pcF=0x20 -> imem_addr stable 0x20, imem_busy=1, three bubbles (validD=0). Redirect to 0x80 in cycle 2 -> SQUASH; returning word discarded, next request at 0x80.
- Redirect presented with stallD=1 -> pcF unchanged, IF/ID held. Reset asserted during SQUASH -> pcF=RESET_PC, state RUN, validD=0.
